mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum consecutive grant cycles per owner; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request vector; req[i] held high by requester i while it wants the shared 4:1 mux path.
REQ-005 gnt  output  4  one-hot or zero grant vector, registered.
REQ-006 s1  output  1  mux select MSB, equal to bit 1 of owner index, registered.
REQ-007 s0  output  1  mux select LSB, equal to bit 0 of owner index, registered.
REQ-008 busy  output  1  high while the FSM is in BUSY.
REQ-009 timeout  output  1  one-cycle pulse when a grant is force-released by the MAX_HOLD limit.

Function
REQ-010 FSM SHALL have exactly two states, IDLE and BUSY; internal state is a 2-bit owner index, a 2-bit last-winner pointer, and an 8-bit hold counter.
REQ-011 Arbitration SHALL be round-robin; search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr updates to each new winner.
REQ-012 IDLE, req != 0 at a rising edge -> BUSY next cycle with gnt one-hot on the winner, {s1,s0} = winner index, hold counter = 0; grant latency is exactly 1 cycle.
REQ-013 IDLE, req == 0 -> remain IDLE; gnt = 0; {s1,s0} keep their last value.
REQ-014 BUSY, req[owner] = 1 and hold counter < MAX_HOLD-1 -> keep grant; hold counter increments by 1.
REQ-015 BUSY, req[owner] = 0 (release) -> arbitrate among the other three bits; winner found: gnt moves to it next cycle with no idle gap and counter = 0; no winner: IDLE, gnt = 0.
REQ-016 BUSY, req[owner] = 1 and hold counter == MAX_HOLD-1 -> forced release; timeout = 1 for the next cycle only; arbitrate excluding owner per REQ-015.
REQ-017 Forced release with no other requester -> owner re-granted, counter = 0, timeout still pulses, gnt stays continuously high.
REQ-018 gnt SHALL never have more than one bit set; gnt != 0 iff busy = 1.
REQ-019 {s1,s0} SHALL change only on the same edge on which gnt changes owner.
REQ-020 Requests arriving or dropping for non-owners SHALL not affect the current grant.
REQ-021 Hold counter SHALL never exceed MAX_HOLD-1 and SHALL never wrap.

Reset
REQ-022 rst_n low SHALL immediately, independent of clk, force state = IDLE, gnt = 4'b0000, s1 = 0, s0 = 0, busy = 0, timeout = 0, ptr = 3 (so requester 0 has first priority), hold counter = 0.
REQ-023 Reset asserted mid-grant SHALL drop gnt without waiting for an edge; after release, first arbitration obeys REQ-022 priority.
REQ-024 Outputs SHALL update only on clk edges after rst_n deassertion.

Verification
REQ-025 After reset, req = 4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001, with each owner releasing after 2 cycles; {s1,s0} = 00, 01, 10, 11, 00 in step.
REQ-026 req = 4'b0100 for 1 cycle from IDLE -> gnt = 0100 and s1s0 = 10 one cycle later; req drop -> gnt = 0000 and busy = 0 the following cycle.
REQ-027 MAX_HOLD = 4, req = 4'b0001 held forever -> gnt = 0001 continuously; timeout pulses every 4 cycles.
REQ-028 MAX_HOLD = 4, req = 4'b0011 held -> gnt alternates 0001, 0010 every 4 cycles; timeout pulses at each switch.
REQ-029 rst_n pulled low during the 2nd grant cycle of owner 2 -> gnt = 0000 and s1s0 = 00 asynchronously; after release with req = 4'b0110, first grant = 0010.
REQ-030 Random req stress for 10k cycles -> gnt always one-hot or zero, {s1,s0} always matches the gnt index while busy, and no requester holding req waits more than 3*MAX_HOLD+3 cycles.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux path.
// Grants are registered and each grant is capped at MAX_HOLD consecutive cycles.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned HOLD_W     = 8;
    localparam int unsigned HOLD_LIMIT = MAX_HOLD - 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, stateNext;
    logic [1:0]          owner, ownerNext;
    logic [1:0]          ptr, ptrNext;
    logic [HOLD_W-1:0]   holdCnt, holdNext;
    logic [3:0]          gntNext;
    logic                s1Next, s0Next, busyNext, timeoutNext;
    logic                found;
    logic [1:0]          winner;
    logic [1:0]          cand;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 2'd0;
            ptr     <= 2'd3;
            holdCnt <= '0;
            gnt     <= 4'b0000;
            s1      <= 1'b0;
            s0      <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= stateNext;
            owner   <= ownerNext;
            ptr     <= ptrNext;
            holdCnt <= holdNext;
            gnt     <= gntNext;
            s1      <= s1Next;
            s0      <= s0Next;
            busy    <= busyNext;
            timeout <= timeoutNext;
        end
    end

    // Next-state logic; while BUSY, ptr equals owner, so the 4th candidate is the owner itself
    always_comb begin
        stateNext   = state;
        ownerNext   = owner;
        ptrNext     = ptr;
        holdNext    = holdCnt;
        gntNext     = gnt;
        s1Next      = s1;
        s0Next      = s0;
        timeoutNext = 1'b0;
        found       = 1'b0;
        winner      = ptr;
        cand        = ptr;

        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand] && !(state == BUSY && k == 4)) begin
                found  = 1'b1;
                winner = cand;
            end
        end

        case (state)
            IDLE: begin
                gntNext = 4'b0000;
                if (found) begin
                    stateNext = BUSY;
                    ownerNext = winner;
                    ptrNext   = winner;
                    holdNext  = '0;
                    gntNext   = 4'(4'b0001 << winner);
                    s1Next    = winner[1];
                    s0Next    = winner[0];
                end
            end
            BUSY: begin
                if (req[owner] && holdCnt < HOLD_W'(HOLD_LIMIT)) begin
                    holdNext = holdCnt + HOLD_W'(1);
                end else begin
                    timeoutNext = req[owner];
                    if (found) begin
                        ownerNext = winner;
                        ptrNext   = winner;
                        holdNext  = '0;
                        gntNext   = 4'(4'b0001 << winner);
                        s1Next    = winner[1];
                        s0Next    = winner[0];
                    end else if (req[owner]) begin
                        holdNext = '0;
                    end else begin
                        stateNext = IDLE;
                        holdNext  = '0;
                        gntNext   = 4'b0000;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        busyNext = (stateNext == BUSY);
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_HOLD 4 and 15) on shared stimulus,
// checked against a queue-free behavioural arbiter model plus directed tables.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gntA [2];
    logic       s1A [2];
    logic       s0A [2];
    logic       busyA [2];
    logic       toA [2];

    int nVec;
    int nErr;

    // Model state per instance: owner -1 means idle
    int mh [2];
    int mOwner [2];
    int mPtr [2];
    int mHold [2];
    int mSel [2];
    int mTo [2];
    int waitCnt [2][4];
    int maxWait [2];

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl [19];

    mux_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gntA[0]),
        .s1(s1A[0]), .s0(s0A[0]), .busy(busyA[0]), .timeout(toA[0])
    );

    mux_rr_arbiter dut15 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gntA[1]),
        .s1(s1A[1]), .s0(s0A[1]), .busy(busyA[1]), .timeout(toA[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int m, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, m, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mOwner[m] = -1;
            mPtr[m]   = 3;
            mHold[m]  = 0;
            mSel[m]   = 0;
            mTo[m]    = 0;
            for (int i = 0; i < 4; i++) waitCnt[m][i] = 0;
        end
    endtask

    // First requester after 'from' in rotating order, skipping 'from' itself when exclOwn
    function automatic int pick(input int from, input logic [3:0] r, input bit exclOwn);
        int last;
        last = exclOwn ? 3 : 4;
        for (int k = 1; k <= last; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic modelEdge(input logic [3:0] r);
        int w;
        bit forced;
        for (int m = 0; m < 2; m++) begin
            mTo[m] = 0;
            if (mOwner[m] < 0) begin
                w = pick(mPtr[m], r, 1'b0);
                if (w >= 0) begin
                    mOwner[m] = w; mPtr[m] = w; mHold[m] = 0; mSel[m] = w;
                end
            end else if (r[mOwner[m]] && mHold[m] < mh[m] - 1) begin
                mHold[m]++;
            end else begin
                forced = r[mOwner[m]];
                mTo[m] = forced;
                w = pick(mOwner[m], r, 1'b1);
                if (w >= 0) begin
                    mOwner[m] = w; mPtr[m] = w; mHold[m] = 0; mSel[m] = w;
                end else if (forced) begin
                    mHold[m] = 0;
                end else begin
                    mOwner[m] = -1; mHold[m] = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (mOwner[m] == i && waitCnt[m][i] > 0)
                    chk("wait_bound", m, int'(waitCnt[m][i] <= 3 * mh[m] + 3), 1);
                if (r[i] && mOwner[m] != i) waitCnt[m][i]++;
                else waitCnt[m][i] = 0;
                if (waitCnt[m][i] > maxWait[m]) maxWait[m] = waitCnt[m][i];
            end
        end
    endtask

    task automatic cmpModel();
        for (int m = 0; m < 2; m++) begin
            chk("gnt", m, int'(gntA[m]), (mOwner[m] < 0) ? 0 : (1 << mOwner[m]));
            chk("busy", m, int'(busyA[m]), int'(mOwner[m] >= 0));
            chk("sel", m, int'({s1A[m], s0A[m]}), mSel[m]);
            chk("timeout", m, int'(toA[m]), mTo[m]);
            chk("onehot0", m, int'($onehot0(gntA[m])), 1);
            if (busyA[m])
                chk("sel_vs_gnt", m, int'(gntA[m]), 1 << {s1A[m], s0A[m]});
        end
    endtask

    // One clock: model sees the req present at the edge, outputs sampled 1 time unit later
    task automatic step();
        logic [3:0] r;
        r = req;
        @(posedge clk);
        modelEdge(r);
        #1;
        cmpModel();
    endtask

    task automatic doReset();
        req   = 4'b0000;
        rst_n = 1'b0;
        modelReset();
        #3;
        for (int m = 0; m < 2; m++) begin
            chk("rst_gnt", m, int'(gntA[m]), 0);
            chk("rst_sel", m, int'({s1A[m], s0A[m]}), 0);
            chk("rst_busy", m, int'(busyA[m]), 0);
            chk("rst_to", m, int'(toA[m]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        nVec = 0;
        nErr = 0;
        mh[0] = 4;
        mh[1] = 15;
        maxWait[0] = 0;
        maxWait[1] = 0;
        req   = 4'b0000;
        rst_n = 1'b0;

        // Directed table for the MAX_HOLD=4 instance
        tbl[0] = '{4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0};
        tbl[1] = '{4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0};
        for (int s = 1; s <= 9; s++)
            tbl[1 + s] = '{4'b0001, 4'b0001, 2'b00, 1'b1, (s == 5 || s == 9)};
        for (int s = 10; s <= 17; s++) begin
            if (s < 13)       tbl[1 + s] = '{4'b0011, 4'b0001, 2'b00, 1'b1, 1'b0};
            else if (s == 13) tbl[1 + s] = '{4'b0011, 4'b0010, 2'b01, 1'b1, 1'b1};
            else if (s < 17)  tbl[1 + s] = '{4'b0011, 4'b0010, 2'b01, 1'b1, 1'b0};
            else              tbl[1 + s] = '{4'b0011, 4'b0001, 2'b00, 1'b1, 1'b1};
        end

        doReset();
        for (int v = 0; v < 19; v++) begin
            req = tbl[v].req;
            step();
            chk("tbl_gnt", 0, int'(gntA[0]), int'(tbl[v].gnt));
            chk("tbl_sel", 0, int'({s1A[0], s0A[0]}), int'(tbl[v].sel));
            chk("tbl_busy", 0, int'(busyA[0]), int'(tbl[v].busy));
            chk("tbl_to", 0, int'(toA[0]), int'(tbl[v].to));
        end

        // All request, each owner drops after two grant cycles
        doReset();
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            for (int m = 0; m < 2; m++) begin
                chk("rr_gnt_c1", m, int'(gntA[m]), 1 << (g % 4));
                chk("rr_sel", m, int'({s1A[m], s0A[m]}), g % 4);
            end
            req = 4'b1111;
            step();
            for (int m = 0; m < 2; m++)
                chk("rr_gnt_c2", m, int'(gntA[m]), 1 << (g % 4));
            req = 4'b1111 & ~(4'b0001 << (g % 4));
            step();
        end

        // Asynchronous reset in owner 2's second grant cycle
        doReset();
        req = 4'b0100;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("async_gnt", m, int'(gntA[m]), 0);
            chk("async_sel", m, int'({s1A[m], s0A[m]}), 0);
            chk("async_busy", m, int'(busyA[m]), 0);
        end
        modelReset();
        req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int m = 0; m < 2; m++)
            chk("post_rst_gnt", m, int'(gntA[m]), 4'b0010);

        // Random stress against the model
        doReset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if ($urandom_range(7) == 0) req[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            step();
        end
        for (int m = 0; m < 2; m++)
            chk("max_wait", m, int'(maxWait[m] <= 3 * mh[m] + 3), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
